// File: rtl/freq_meter.sv
// freq_meter
//
// Gated frequency and period meter for an asynchronous square wave.
// Rising edges of sig_in are counted over back-to-back windows of
// GATE_CYCLES clocks; each window result is handed to a consumer through a
// valid/ack handshake. Independently, the period of the most recent input
// cycle (in clk cycles) is reported continuously while en is high.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   en           measurement enable (synchronous to clk)
//   sig_in       signal under measurement (asynchronous to clk)
//   ack          consumer acknowledge of freq_out
//   freq_out     rising edges counted in the last completed gate window
//   freq_valid   freq_out holds an unacknowledged result
//   freq_ovf     edge count saturated in the window reported by freq_out
//   overrun      a result was overwritten before being acknowledged (sticky)
//   period_out   clk cycles between the last two rising edges of sig_in
//   period_valid period_out holds a real measurement
//   busy         FSM is in GATE (doubles as the FSM state observation point)
//
// Handshake: freq_valid rises when a window result is latched and holds
// until the consumer pulses ack. An ack with no latch in the same cycle
// clears freq_valid and overrun. A latch while freq_valid=1 and ack=0
// overwrites freq_out and sets overrun. A latch coincident with ack loads
// the new result, keeps freq_valid=1 and clears overrun. ack while
// freq_valid=0 has no effect.

module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CW          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          sig_in,
   input  logic          ack,
   output logic [CW-1:0] freq_out,
   output logic          freq_valid,
   output logic          freq_ovf,
   output logic          overrun,
   output logic [CW-1:0] period_out,
   output logic          period_valid,
   output logic          busy
);

   localparam int            GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   state_t        state;
   logic [GW-1:0] gate_cnt;
   logic [CW-1:0] edge_cnt;
   logic          sat;

   logic          s1, s2, s3;
   logic          rise;

   logic [CW-1:0] per_cnt;
   logic          armed;

   // s1 is the metastability flop; s2/s3 form the edge detector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Next edge count including this cycle's rise. sat marks an edge that
   // was lost because the counter was already at its maximum.
   logic          edge_at_max;
   logic [CW-1:0] edge_next;
   logic          sat_next;
   logic          gate_last;
   logic          latch;

   assign edge_at_max = (edge_cnt == CNT_MAX);
   assign edge_next   = (rise && !edge_at_max) ? edge_cnt + CW'(1) : edge_cnt;
   assign sat_next    = sat | (rise & edge_at_max);
   assign gate_last   = (gate_cnt == GATE_LAST);
   assign latch       = (state == GATE) && en && gate_last;

   // Gate FSM. The terminal cycle restarts the window in place so windows
   // abut with no dead cycle; dropping en discards the partial window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state    <= GATE;
                  busy     <= 1'b1;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end
            end
            GATE: begin
               if (!en) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (gate_last) begin
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GW'(1);
                  edge_cnt <= edge_next;
                  sat      <= sat_next;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Result register and handshake. overrun can only be set while a result
   // is still pending, so it never outlives freq_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_out   <= '0;
         freq_valid <= 1'b0;
         freq_ovf   <= 1'b0;
         overrun    <= 1'b0;
      end else if (latch) begin
         freq_out   <= edge_next;
         freq_ovf   <= sat_next;
         freq_valid <= 1'b1;
         overrun    <= ~ack & (freq_valid | overrun);
      end else if (ack) begin
         freq_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

   // Period path, independent of gate boundaries. The first rise after en
   // only aligns per_cnt; a saturated period_out means a stopped/slow input.
   logic [CW-1:0] per_inc;

   assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt      <= '0;
         armed        <= 1'b0;
         period_out   <= '0;
         period_valid <= 1'b0;
      end else if (!en) begin
         per_cnt <= '0;
         armed   <= 1'b0;
      end else if (rise) begin
         per_cnt <= '0;
         armed   <= 1'b1;
         if (armed) begin
            period_out   <= per_inc;
            period_valid <= 1'b1;
         end
      end else begin
         per_cnt <= per_inc;
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: a GATE_CYCLES=1000/CW=32 instance for the main
// scenarios and a GATE_CYCLES=200/CW=4 instance for saturation.
module tb_freq_meter;

   localparam int CW     = 32;
   localparam int GATE   = 1000;
   localparam int CW4    = 4;
   localparam int GATE4  = 200;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic          en, ack, sig_in;
   logic [CW-1:0] freq_out, period_out;
   logic          freq_valid, freq_ovf, overrun, period_valid, busy;

   logic           en4, ack4;
   logic [CW4-1:0] freq_out4, period_out4;
   logic           freq_valid4, freq_ovf4, overrun4, period_valid4, busy4;

   freq_meter #(.GATE_CYCLES(GATE), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .ack(ack),
      .freq_out(freq_out), .freq_valid(freq_valid), .freq_ovf(freq_ovf),
      .overrun(overrun), .period_out(period_out),
      .period_valid(period_valid), .busy(busy)
   );

   freq_meter #(.GATE_CYCLES(GATE4), .CW(CW4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .sig_in(sig_in), .ack(ack4),
      .freq_out(freq_out4), .freq_valid(freq_valid4), .freq_ovf(freq_ovf4),
      .overrun(overrun4), .period_out(period_out4),
      .period_valid(period_valid4), .busy(busy4)
   );

   // ---------------- counters / scoreboard ----------------
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [CW-1:0] val;
      logic [CW-1:0] tol;
   } exp_t;
   exp_t exp_q[$];

   // ---------------- square-wave driver ----------------
   int hi_len = 5;
   int lo_len = 5;
   int ph_cnt = 0;
   bit sig_stop = 1'b0;

   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         if (sig_stop) begin
            sig_in = 1'b0;
            ph_cnt = 0;
         end else begin
            ph_cnt++;
            if (ph_cnt >= (sig_in ? hi_len : lo_len)) begin
               sig_in = ~sig_in;
               ph_cnt = 0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input logic [CW-1:0] v, input logic [CW-1:0] t);
      exp_t e;
      e.val = v;
      e.tol = t;
      exp_q.push_back(e);
   endtask

   task automatic do_ack;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (freq_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      checks++;
      if ({freq_out, freq_valid, freq_ovf, overrun, period_out, period_valid, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: fo=%0d fv=%b ovf=%b ovr=%b po=%0d pv=%b busy=%b, expected all 0",
                  freq_out, freq_valid, freq_ovf, overrun, period_out, period_valid, busy);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || freq_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b fv=%b, expected 0 0", busy, freq_valid);
      end
   endtask

   task automatic test_basic;
      int t_prev;
      bit ok;
      exp_t e;
      hi_len = 5;
      lo_len = 5;
      repeat (30) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || period_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_entry: busy=%b pv=%b, expected 1 0", busy, period_valid);
      end
      t_prev = cyc;
      push_exp(100, 1);
      push_exp(100, 0);
      push_exp(100, 0);
      for (int w = 0; w < 3; w++) begin
         wait_valid(GATE + 100, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: freq_valid=0 after %0d cycles, expected 1", GATE + 100);
            return;
         end
         checks++;
         if (cyc - t_prev != GATE) begin
            errors++;
            $display("FAIL basic_spacing: result after %0d cycles, expected %0d", cyc - t_prev, GATE);
         end
         e = exp_q.pop_front();
         checks++;
         if ($isunknown(freq_out) || (freq_out + e.tol < e.val) || (freq_out > e.val + e.tol)) begin
            errors++;
            $display("FAIL basic_freq: freq_out=%0d expected %0d +/-%0d", freq_out, e.val, e.tol);
         end
         t_prev = cyc;
         do_ack;
         checks++;
         if (freq_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_clear: freq_valid=%b expected 0", freq_valid);
         end
      end
      checks++;
      if (period_out !== 10 || period_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_period: po=%0d pv=%b, expected 10 1", period_out, period_valid);
      end
   endtask

   task automatic test_overrun;
      int l1;
      bit ok;
      exp_t e;
      push_exp(100, 0);
      wait_valid(GATE + 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ovr_timeout: freq_valid=0, expected 1");
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (freq_out !== e.val) begin
         errors++;
         $display("FAIL ovr_first: freq_out=%0d expected %0d", freq_out, e.val);
      end
      l1 = cyc;
      do_ack;
      push_exp(100, 0);
      push_exp(125, 3);
      push_exp(125, 0);
      // first withheld window: pending result, no overrun yet
      while (cyc < l1 + GATE) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (freq_valid !== 1'b1 || overrun !== 1'b0 || freq_out !== e.val) begin
         errors++;
         $display("FAIL ovr_pending: fv=%b ovr=%b fo=%0d, expected 1 0 %0d", freq_valid, overrun, freq_out, e.val);
      end
      hi_len = 4;
      lo_len = 4;
      // second withheld window: overwritten, overrun set
      while (cyc < l1 + 2 * GATE) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (freq_valid !== 1'b1 || overrun !== 1'b1 ||
          (freq_out + e.tol < e.val) || (freq_out > e.val + e.tol)) begin
         errors++;
         $display("FAIL ovr_set: fv=%b ovr=%b fo=%0d, expected 1 1 %0d+/-%0d",
                  freq_valid, overrun, freq_out, e.val, e.tol);
      end
      // ack exactly in the terminal cycle of the next window
      while (cyc < l1 + 3 * GATE - 1) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (freq_valid !== 1'b1 || overrun !== 1'b0 || freq_out !== e.val) begin
         errors++;
         $display("FAIL ovr_coincident: fv=%b ovr=%b fo=%0d, expected 1 0 %0d", freq_valid, overrun, freq_out, e.val);
      end
   endtask

   task automatic test_abort;
      int l4, t_entry;
      bit ok;
      exp_t e;
      l4 = cyc;
      do_ack;
      while (cyc < l4 + 500) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: busy=%b expected 0", busy);
      end
      checks++;
      if (freq_out !== 125 || freq_valid !== 1'b0 || period_out !== 8 || period_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_retain: fo=%0d fv=%b po=%0d pv=%b, expected 125 0 8 1",
                  freq_out, freq_valid, period_out, period_valid);
      end
      while (cyc < l4 + 520) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      t_entry = cyc;
      push_exp(125, 1);
      wait_valid(GATE + 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL abort_timeout: freq_valid=0, expected 1");
         return;
      end
      checks++;
      if (cyc - t_entry != GATE) begin
         errors++;
         $display("FAIL abort_spacing: result %0d cycles after re-entry, expected %0d", cyc - t_entry, GATE);
      end
      e = exp_q.pop_front();
      checks++;
      if ((freq_out + e.tol < e.val) || (freq_out > e.val + e.tol)) begin
         errors++;
         $display("FAIL abort_freq: freq_out=%0d expected %0d +/-%0d", freq_out, e.val, e.tol);
      end
   endtask

   task automatic test_async_reset;
      int t_entry;
      bit ok;
      exp_t e;
      hi_len = 5;
      lo_len = 5;
      repeat (300) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || freq_valid !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: busy=%b fv=%b, expected 1 1", busy, freq_valid);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({freq_out, freq_valid, freq_ovf, overrun, period_out, period_valid, busy} !== '0) begin
         errors++;
         $display("FAIL areset_now: fo=%0d fv=%b ovf=%b ovr=%b po=%0d pv=%b busy=%b, expected all 0",
                  freq_out, freq_valid, freq_ovf, overrun, period_out, period_valid, busy);
      end
      en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL areset_idle: busy=%b expected 0", busy);
      end
      repeat (20) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      t_entry = cyc;
      push_exp(100, 1);
      wait_valid(GATE + 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL areset_timeout: freq_valid=0, expected 1");
         return;
      end
      checks++;
      if (cyc - t_entry != GATE) begin
         errors++;
         $display("FAIL areset_spacing: result after %0d cycles, expected %0d", cyc - t_entry, GATE);
      end
      e = exp_q.pop_front();
      checks++;
      if ((freq_out + e.tol < e.val) || (freq_out > e.val + e.tol) || freq_ovf !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL areset_freq: fo=%0d ovf=%b ovr=%b, expected %0d+/-%0d 0 0",
                  freq_out, freq_ovf, overrun, e.val, e.tol);
      end
      checks++;
      if (period_out !== 10 || period_valid !== 1'b1) begin
         errors++;
         $display("FAIL areset_period: po=%0d pv=%b, expected 10 1", period_out, period_valid);
      end
      do_ack;
   endtask

   task automatic test_min_width;
      bit ok;
      exp_t e;
      en = 1'b0;
      hi_len = 2;
      lo_len = 2;
      repeat (20) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      push_exp(250, 1);
      push_exp(250, 0);
      for (int w = 0; w < 2; w++) begin
         wait_valid(GATE + 100, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL minw_timeout: freq_valid=0, expected 1");
            return;
         end
         e = exp_q.pop_front();
         checks++;
         if ((freq_out + e.tol < e.val) || (freq_out > e.val + e.tol)) begin
            errors++;
            $display("FAIL minw_freq: freq_out=%0d expected %0d +/-%0d", freq_out, e.val, e.tol);
         end
         do_ack;
      end
      checks++;
      if (period_out !== 4) begin
         errors++;
         $display("FAIL minw_period: period_out=%0d expected 4", period_out);
      end
      en = 1'b0;
   endtask

   task automatic test_saturation;
      bit ok;
      hi_len = 4;
      lo_len = 4;
      repeat (20) @(negedge clk);
      en4 = 1'b1;
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b1) begin
         errors++;
         $display("FAIL sat_busy: busy=%b expected 1", busy4);
      end
      ok = 1'b0;
      for (int i = 0; i < GATE4 + 50; i++) begin
         @(negedge clk);
         if (freq_valid4 === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sat_timeout: freq_valid=0, expected 1");
         return;
      end
      checks++;
      if (freq_out4 !== 4'd15 || freq_ovf4 !== 1'b1 || overrun4 !== 1'b0) begin
         errors++;
         $display("FAIL sat_freq: fo=%0d ovf=%b ovr=%b, expected 15 1 0", freq_out4, freq_ovf4, overrun4);
      end
      checks++;
      if (period_out4 !== 4'd8 || period_valid4 !== 1'b1) begin
         errors++;
         $display("FAIL sat_period8: po=%0d pv=%b, expected 8 1", period_out4, period_valid4);
      end
      sig_stop = 1'b1;
      repeat (40) @(negedge clk);
      sig_stop = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (period_out4 !== 4'd8) break;
      end
      checks++;
      if (period_out4 !== 4'd15) begin
         errors++;
         $display("FAIL sat_period_stop: po=%0d expected 15", period_out4);
      end
      en4 = 1'b0;
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      ack   = 1'b0;
      en4   = 1'b0;
      ack4  = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_basic;
      test_overrun;
      test_abort;
      test_async_reset;
      test_min_width;
      test_saturation;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results still queued, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency and period meter for an asynchronous square-wave input. It counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` system clocks and hands each result to a consumer through a valid/ack handshake. It also reports, continuously, the period of the most recent input cycle in system clocks. It sits beside the divider tick generators and measures external or internally generated square waves, including the divider's own 400 Hz / 40 Hz / 2 Hz outputs in self-test.

## Interface

Parameters:
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles, ≥ 2.
- `CW`, default 32: width of the count and period results.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input, 1: system clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous active-low reset.
- `en` input, 1: measurement enable, synchronous to `clk`.
- `sig_in` input, 1: signal under measurement, asynchronous to `clk`.
- `ack` input, 1: consumer acknowledges `freq_out`.
- `freq_out` output, CW: rising edges counted in the last completed gate.
- `freq_valid` output, 1: `freq_out` holds an unacknowledged result.
- `freq_ovf` output, 1: edge count saturated in the window reported by `freq_out`.
- `overrun` output, 1: a result was overwritten before it was acked.
- `period_out` output, CW: `clk` cycles between the last two rising edges.
- `period_valid` output, 1: `period_out` holds a real measurement.
- `busy` output, 1: FSM is in GATE.

## Operation

- Input path: 3-flop chain `s1 <= sig_in`, `s2 <= s1`, `s3 <= s2`. `rise = s2 & ~s3` is a combinational 1-cycle pulse. Supported input: high and low times each ≥ 2 `clk` cycles.
- FSM states:
  - IDLE (reset state). `en`=1 moves to GATE, with `gate_cnt`=0 and `edge_cnt`=0.
  - GATE. On each cycle, `edge_cnt` increments when `rise` is high. It saturates at 2^CW-1 and sets an internal `sat` bit.
  - GATE, `gate_cnt`==GATE_CYCLES-1 (terminal cycle):
    - `freq_out` <= `edge_cnt`, plus 1 if `rise` is high this cycle (still saturating).
    - `freq_ovf` <= `sat`, or saturation occurring on this increment.
    - `freq_valid` <= 1.
    - `gate_cnt`, `edge_cnt` and `sat` clear, and the FSM stays in GATE. Windows are back-to-back with no dead cycle.
  - GATE, `en`=0 in any cycle: return to IDLE and discard the partial count. `freq_out`, `freq_valid`, `freq_ovf` and `overrun` are retained.
- Handshake:
  - `ack`=1 with no latch in that cycle: clears `freq_valid` and `overrun`.
  - Latch while `freq_valid`=1 and `ack`=0: overwrite `freq_out`, set `overrun`=1, which is sticky until acked.
  - Latch and `ack` in the same cycle: new result loaded, `freq_valid` stays 1, `overrun` <= 0.
  - `ack` while `freq_valid`=0: no effect.
- Period path (runs whenever `en`=1, independent of gate boundaries):
  - `per_cnt` increments every cycle and saturates at 2^CW-1.
  - On `rise`: `period_out` <= `per_cnt`+1 (saturating), and `per_cnt` <= 0.
  - The first `rise` after `en` goes high only restarts `per_cnt` and does not update `period_out`. `period_valid` <= 1 from the second `rise` onward.
  - A saturated `period_out` indicates the input is stopped or too slow.
  - `en`=0: `per_cnt` cleared, first-edge flag cleared. `period_out` and `period_valid` are retained.

## Timing

- Reset values: all outputs 0, FSM in IDLE, all counters and synchronizer flops 0.
- `sig_in` rising before clk edge k appears as `rise` high between edges k+1 and k+2, and is counted at edge k+2.
- `busy` goes to 1 at the edge after `en` is sampled high, and to 0 at the edge after `en` is sampled low.
- Gate window: cycles 0..GATE_CYCLES-1 after entry. `freq_valid` rises at the edge ending the terminal cycle. The next result arrives exactly GATE_CYCLES cycles later.
- Edges in the 2-cycle synchronizer pipeline at a window boundary are counted in the window where `rise` appears.
- `period_out` updates at the same edge that counts the `rise`.

## Test plan

- GATE_CYCLES=1000, `sig_in` period 10 clk (5 high / 5 low), `en` held → every `freq_out`=100 (±1 on the first window only), `period_out`=10, `period_valid`=1 after the 2nd rise, `freq_valid` pulses every 1000 cycles.
- `ack` the first result, then withhold `ack` for 2 windows → `overrun`=1 and `freq_out` equals the latest window. Then an `ack` coincident with a latch → `freq_valid`=1, `overrun`=0.
- Drop `en` at gate cycle 500, re-raise it 20 cycles later → no latch from the aborted window; the next `freq_valid` arrives 1000 cycles after re-entry; old `freq_out` retained meanwhile.
- CW=4, GATE_CYCLES=200, period 8 clk → edge count saturates: `freq_out`=15, `freq_ovf`=1. Stop `sig_in` → `period_out` saturates to 15 at the next rise.
- Assert `rst_n`=0 mid-gate for a partial cycle → all outputs 0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE and a clean first window matches the first scenario.
- `sig_in` at minimum supported width (2 high / 2 low) → period 4, `freq_out`=250 with GATE_CYCLES=1000.
